// File: rtl/mode_pkg.sv
// Purpose : Shared definitions for the mode decoder slice. It holds the field
//           positions inside the 4-bit mode code, the code width, the
//           "all lines off" word and a one-hot helper.
// Ports   : none (package).
package mode_pkg;

  localparam int MODE_W       = 4;
  localparam int MODE_EN_BIT  = 3;
  localparam int MODE_INV_BIT = 2;
  localparam int MODE_SEL_MSB = 1;
  localparam int MODE_SEL_LSB = 0;

  localparam logic [MODE_W-1:0] MODE_OFF = 4'b0000;

  // Converts the 2-bit line select into a one-hot line word.
  function automatic logic [MODE_W-1:0] mode_onehot(input logic [1:0] sel);
    logic [MODE_W-1:0] oh;
    oh = 4'b0001 << sel;
    return oh;
  endfunction

endpackage

// File: rtl/mode_sync.sv
// Purpose : Chain of flip-flops that brings an asynchronous multi-bit input
//           into the clk domain. All bits move in parallel. STAGES=0 turns
//           the chain into a plain wire, for inputs that are already
//           synchronous.
// Ports   : clk   - clock, all flops rising-edge
//           rst_n - asynchronous active-low reset, clears the chain to 0
//           i_d   - raw input word
//           o_q   - synchronised word (last stage of the chain)
module mode_sync #(
  parameter int DATA_W = 4,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] i_d,
  output logic [DATA_W-1:0] o_q
);

  generate
    if (STAGES == 0) begin : g_bypass
      // No flops here, so the clock and reset have nothing to drive.
      logic w_unused;
      assign w_unused = clk ^ rst_n;
      assign o_q      = i_d;
    end else begin : g_chain
      logic [DATA_W-1:0] r_chain [STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES; i++) r_chain[i] <= '0;
        end else begin
          r_chain[0] <= i_d;
          for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
        end
      end

      assign o_q = r_chain[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/mode_decoder.sv
// Purpose : Turns a 4-bit mode code into a registered 4-bit line-select word.
//           Code bit 3 enables the output, bit 2 inverts it, and bits 1:0
//           pick one of four lines. The input is synchronised first, and a
//           one-cycle pulse flags every change of the output word.
// Ports   : clk        - clock, all state rising-edge
//           rst_n      - asynchronous active-low reset
//           mode_d     - raw mode code [3]=enable [2]=invert [1:0]=select
//           mode_a     - decoded line-select word (registered)
//           mode_valid - registered copy of the synchronised enable bit
//           mode_chg   - one-cycle pulse, high when mode_a takes a new value
module mode_decoder
  import mode_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [MODE_W-1:0] RESET_CODE  = 4'b0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode_d,
  output logic [MODE_W-1:0] mode_a,
  output logic              mode_valid,
  output logic              mode_chg
);

  function automatic logic [MODE_W-1:0] decode(input logic [MODE_W-1:0] code);
    logic [MODE_W-1:0] oh;
    logic [MODE_W-1:0] word;
    oh = mode_onehot(code[MODE_SEL_MSB:MODE_SEL_LSB]);
    if (!code[MODE_EN_BIT])       word = MODE_OFF;
    else if (code[MODE_INV_BIT])  word = ~oh;
    else                          word = oh;
    return word;
  endfunction

  logic [MODE_W-1:0] w_code_s;
  logic [MODE_W-1:0] w_next_a;

  logic [MODE_W-1:0] r_mode_a;
  logic              r_mode_valid;
  logic              r_mode_chg;
  logic              r_primed;

  mode_sync #(
    .DATA_W (MODE_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (mode_d),
    .o_q   (w_code_s)
  );

  assign w_next_a = decode(w_code_s);

  // r_primed stays low for the first edge after reset, so the jump from
  // RESET_CODE to the first decoded word cannot raise a change pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_a     <= RESET_CODE;
      r_mode_valid <= 1'b0;
      r_mode_chg   <= 1'b0;
      r_primed     <= 1'b0;
    end else begin
      r_mode_a     <= w_next_a;
      r_mode_valid <= w_code_s[MODE_EN_BIT];
      r_mode_chg   <= r_primed && (w_next_a != r_mode_a);
      r_primed     <= 1'b1;
    end
  end

  assign mode_a     = r_mode_a;
  assign mode_valid = r_mode_valid;
  assign mode_chg   = r_mode_chg;

endmodule

// File: tb/tb_mode_decoder.sv
// Bench for mode_decoder. A reference model follows the decoder at the
// level of "the code seen SYNC edges ago, looked up in the mode table".
module tb_mode_decoder;

  localparam int SYNC = 2;
  localparam logic [3:0] RST_CODE = 4'b0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] mode_d = 4'b0000;
  logic [3:0] mode_a;
  logic       mode_valid;
  logic       mode_chg;

  mode_decoder #(
    .SYNC_STAGES (SYNC),
    .RESET_CODE  (RST_CODE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_d     (mode_d),
    .mode_a     (mode_a),
    .mode_valid (mode_valid),
    .mode_chg   (mode_chg)
  );

  always #5 clk = ~clk;

  // Full code-to-word table.
  logic [3:0] MAP [16];

  int passes = 0;
  int total  = 0;

  // Reference model state.
  int         q[$];
  logic [3:0] exp_a;
  logic       exp_v;
  logic       exp_chg;
  logic [3:0] prev_a;
  bit         first_edge;
  int         pulses;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
  endtask

  task automatic model_reset();
    q.delete();
    for (int i = 0; i < SYNC; i++) q.push_back(0);
    exp_a      = RST_CODE;
    exp_v      = 1'b0;
    exp_chg    = 1'b0;
    prev_a     = RST_CODE;
    first_edge = 1'b1;
  endtask

  // Drive one code for one clock edge, advance the model, check outputs.
  task automatic step(input string tag, input logic [3:0] d);
    int cs;
    mode_d = d;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      q.push_back(int'(d));
      cs         = q.pop_front();
      exp_a      = MAP[cs];
      exp_v      = (cs >= 8);
      exp_chg    = !first_edge && (exp_a != prev_a);
      prev_a     = exp_a;
      first_edge = 1'b0;
    end
    #1;
    chk({tag, "_a"},   mode_a,     exp_a);
    chk({tag, "_v"},   mode_valid, exp_v);
    chk({tag, "_chg"}, mode_chg,   exp_chg);
    if (mode_chg === 1'b1) pulses++;
  endtask

  initial begin
    MAP = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0,
            4'h1, 4'h2, 4'h4, 4'h8, 4'hE, 4'hD, 4'hB, 4'h7};
    model_reset();

    // Reset held with an enabled code on the input.
    mode_d = 4'b1011;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_a", mode_a, 4'b0000);
    chk("rst_async_v", mode_valid, 1'b0);
    chk("rst_async_chg", mode_chg, 1'b0);
    repeat (4) step("rst_hold", 4'b1011);
    rst_n = 1'b1;
    pulses = 0;
    step("rst_rel", 4'b1011);
    chk("rst_first_chg", mode_chg, 1'b0);
    repeat (6) step("rst_fill", 4'b1011);
    chk("rst_fill_a", mode_a, 4'b1000);

    // Sweep every code.
    for (int c = 0; c < 16; c++) begin
      repeat (10) step("sweep", 4'(c));
      chk("sweep_map", mode_a, MAP[c]);
      chk("sweep_valid", mode_valid, (c >= 8));
    end

    // Latency 0000 -> 1000.
    repeat (6) step("lat_pre", 4'b0000);
    step("lat_e1", 4'b1000);
    chk("lat_e1_a", mode_a, 4'b0000);
    step("lat_e2", 4'b1000);
    chk("lat_e2_a", mode_a, 4'b0000);
    step("lat_e3", 4'b1000);
    chk("lat_e3_a", mode_a, 4'b0001);
    chk("lat_e3_chg", mode_chg, 1'b1);
    step("lat_e4", 4'b1000);
    chk("lat_e4_chg", mode_chg, 1'b0);

    // Code changes that leave the output untouched.
    repeat (5) step("nc_a", 4'b0011);
    pulses = 0;
    repeat (5) step("nc_b", 4'b0101);
    chk("nc_dis_a", mode_a, 4'b0000);
    chk("nc_dis_pulses", pulses, 0);
    repeat (5) step("nc_c", 4'b1000);
    pulses = 0;
    repeat (6) step("nc_d", 4'b1000);
    chk("nc_hold_pulses", pulses, 0);

    // Polarity flip.
    repeat (5) step("pol_a", 4'b1001);
    chk("pol_before", mode_a, 4'b0010);
    pulses = 0;
    repeat (5) step("pol_b", 4'b1101);
    chk("pol_after", mode_a, 4'b1101);
    chk("pol_pulses", pulses, 1);

    // Back-to-back code changes on consecutive edges.
    step("b2b", 4'b1000);
    step("b2b", 4'b1001);
    step("b2b", 4'b1010);
    step("b2b", 4'b1011);
    step("b2b", 4'b1100);
    repeat (4) step("b2b_tail", 4'b1100);

    // Random codes with random hold lengths.
    for (int i = 0; i < 80; i++) begin
      logic [3:0] d;
      int n;
      d = 4'($urandom_range(0, 15));
      n = $urandom_range(1, 4);
      repeat (n) step("rnd", d);
    end

    // Reset mid-run, between clock edges.
    repeat (6) step("mid_f", 4'hF);
    chk("mid_pre_a", mode_a, 4'b0111);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_async_a", mode_a, 4'b0000);
    chk("mid_async_v", mode_valid, 1'b0);
    chk("mid_async_chg", mode_chg, 1'b0);
    repeat (2) step("mid_hold", 4'hF);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) step("mid_refill", 4'hF);
    chk("mid_refill_a", mode_a, 4'b0111);
    chk("mid_refill_pulses", pulses, 1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
